// File: rtl/mux_arb_pkg.sv
// ============================================================================
//  Module      : mux_arb_pkg
//  Description : Shared types for the two-requester mux arbiter: FSM state
//                encoding and owner encoding (owner value equals mux select).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

   // Arbiter FSM states; explicit 2-bit encoding.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_e;

   // Owner encoding deliberately matches the mux select value.
   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

endpackage : mux_arb_pkg

`default_nettype wire

// File: rtl/mux_arbiter_mux.sv
// ============================================================================
//  Module      : mux
//  Description : 1-bit 2:1 multiplexer; sel=0 passes a, sel=1 passes b.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux (
   input  logic a,
   input  logic b,
   input  logic sel,
   output logic out
);

   // Pure combinational select; no state in the datapath.
   assign out = sel ? b : a;

endmodule : mux

`default_nettype wire

// File: rtl/mux_arbiter.sv
// ============================================================================
//  Module      : mux_arbiter
//  Description : Two-requester arbiter driving a shared 2:1 mux. Grants are
//                held for at least HOLD_CYCLES; simultaneous requests from
//                idle go to the requester not served last. Handover between
//                owners happens on a single edge with no idle bubble.
//  Config      : define MUX_ARB_TIMEOUT_EN to pre-empt an owner whose grant
//                has lasted MAX_CYCLES while the other side is requesting.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int MAX_CYCLES  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic req_a,
   input  logic req_b,
   input  logic a,
   input  logic b,
   output logic gnt_a,
   output logic gnt_b,
   output logic sel,
   output logic out
);

   localparam int               CNT_W  = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_CYCLES);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_ZERO = '0;

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic             last_owner_q, last_owner_d;
   logic             sel_q, sel_d;
   logic             gnt_a_q, gnt_a_d;
   logic             gnt_b_q, gnt_b_d;

   logic             w_hold_met;
   logic             w_timeout_a;
   logic             w_timeout_b;
   logic             w_leave_a;
   logic             w_leave_b;

   assign w_hold_met = (hold_cnt_q >= C_HOLD);

`ifdef MUX_ARB_TIMEOUT_EN
   // An owner that has used up MAX_CYCLES yields when the other side waits.
   assign w_timeout_a = (hold_cnt_q >= C_MAX) && req_b;
   assign w_timeout_b = (hold_cnt_q >= C_MAX) && req_a;
`else
   assign w_timeout_a = 1'b0;
   assign w_timeout_b = 1'b0;
`endif

   // Owner leaves once its minimum hold is done and it stopped requesting,
   // or when pre-empted by the timeout.
   assign w_leave_a = (!req_a && w_hold_met) || w_timeout_a;
   assign w_leave_b = (!req_b && w_hold_met) || w_timeout_b;

   // Next-state, hold counter, fairness and registered-output computation.
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      last_owner_d = last_owner_q;
      sel_d        = sel_q;
      gnt_a_d      = 1'b0;
      gnt_b_d      = 1'b0;

      case (state_q)
         IDLE: begin
            // On a tie, the requester that was not served last wins.
            if (req_a && (!req_b || (last_owner_q == OWNER_B))) begin
               state_d = OWN_A;
            end else if (req_b) begin
               state_d = OWN_B;
            end
         end
         OWN_A: begin
            if (w_leave_a) begin
               state_d = req_b ? OWN_B : IDLE;
            end
         end
         OWN_B: begin
            if (w_leave_b) begin
               state_d = req_a ? OWN_A : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Counter restarts at 1 on every new ownership, clears in idle,
      // otherwise counts up and saturates at MAX_CYCLES.
      if (state_d == IDLE) begin
         hold_cnt_d = C_ZERO;
      end else if (state_d != state_q) begin
         hold_cnt_d = C_ONE;
      end else if (hold_cnt_q < C_MAX) begin
         hold_cnt_d = hold_cnt_q + C_ONE;
      end

      // Grants and select follow the next state so a handover moves both
      // on the same edge; select keeps its last value while idle.
      case (state_d)
         OWN_A: begin
            last_owner_d = OWNER_A;
            sel_d        = OWNER_A;
            gnt_a_d      = 1'b1;
         end
         OWN_B: begin
            last_owner_d = OWNER_B;
            sel_d        = OWNER_B;
            gnt_b_d      = 1'b1;
         end
         default: begin
            sel_d = sel_q;
         end
      endcase
   end

   // State register with synchronous reset; reset overrides any pending
   // handover or pre-emption.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_cnt_q   <= C_ZERO;
         last_owner_q <= OWNER_B;
         sel_q        <= 1'b0;
         gnt_a_q      <= 1'b0;
         gnt_b_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         last_owner_q <= last_owner_d;
         sel_q        <= sel_d;
         gnt_a_q      <= gnt_a_d;
         gnt_b_q      <= gnt_b_d;
      end
   end

   assign gnt_a = gnt_a_q;
   assign gnt_b = gnt_b_q;
   assign sel   = sel_q;

   mux u_mux (
      .a   (a),
      .b   (b),
      .sel (sel_q),
      .out (out)
   );

endmodule : mux_arbiter

`default_nettype wire

// File: tb/tb_mux_arbiter.sv
// ============================================================================
//  Module      : tb_mux_arbiter
//  Description : Self-checking bench for mux_arbiter (HOLD_CYCLES=4,
//                MAX_CYCLES=16). Expected grant/select/output values per
//                cycle are queued before each edge and compared after it.
//  Config      : honours MUX_ARB_TIMEOUT_EN for the timeout scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_a = 1'b0;
   logic req_b = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic gnt_a, gnt_b, sel, out;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic ga;
      logic gb;
      logic s;
      logic o;
   } exp_t;

   exp_t sb[$];

   mux_arbiter #(
      .HOLD_CYCLES (4),
      .MAX_CYCLES  (16)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req_a (req_a),
      .req_b (req_b),
      .a     (a),
      .b     (b),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b),
      .sel   (sel),
      .out   (out)
   );

   always #5 clk = ~clk;

   // Advance one edge; sample point is 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Put the DUT into a known reset state; no comparisons here.
   task automatic apply_reset();
      rst   = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Queue one expectation; out is derived from the data held this cycle.
   task automatic push_exp(input logic ga, input logic gb, input logic s);
      exp_t e;
      e.ga = ga;
      e.gb = gb;
      e.s  = s;
      e.o  = s ? b : a;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      exp_t e;
      rst   = 1'b1;
      req_a = 1'b1;
      req_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         a   = 1'($urandom);
         b   = 1'($urandom);
         rst = (i < 3);
         // During reset nothing is granted; first free edge grants A.
         if (i < 3) push_exp(1'b0, 1'b0, 1'b0);
         else       push_exp(1'b1, 1'b0, 1'b0);
         tick();
         e = sb.pop_front();
         checks++;
         if ({gnt_a, gnt_b, sel, out} !== {e.ga, e.gb, e.s, e.o}) begin
            errors++;
            $display("FAIL reset cyc %0d: got ga=%b gb=%b sel=%b out=%b want ga=%b gb=%b sel=%b out=%b",
                     i, gnt_a, gnt_b, sel, out, e.ga, e.gb, e.s, e.o);
         end
      end
   endtask

   task automatic test_min_hold();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         req_a = (i == 0);
         req_b = 1'b0;
         a     = 1'($urandom);
         b     = 1'($urandom);
         push_exp(i < 4, 1'b0, 1'b0);
         tick();
         e = sb.pop_front();
         checks++;
         if ({gnt_a, gnt_b, sel, out} !== {e.ga, e.gb, e.s, e.o}) begin
            errors++;
            $display("FAIL min_hold cyc %0d: got ga=%b gb=%b sel=%b out=%b want ga=%b gb=%b sel=%b out=%b",
                     i, gnt_a, gnt_b, sel, out, e.ga, e.gb, e.s, e.o);
         end
      end
   endtask

   task automatic test_round_robin();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 9; i++) begin
         req_a = (i < 5);
         req_b = 1'b1;
         a     = 1'($urandom);
         b     = 1'($urandom);
         push_exp(i < 5, i >= 5, i >= 5);
         tick();
         e = sb.pop_front();
         checks++;
         if ({gnt_a, gnt_b, sel, out} !== {e.ga, e.gb, e.s, e.o}) begin
            errors++;
            $display("FAIL round_robin cyc %0d: got ga=%b gb=%b sel=%b out=%b want ga=%b gb=%b sel=%b out=%b",
                     i, gnt_a, gnt_b, sel, out, e.ga, e.gb, e.s, e.o);
         end
      end
   endtask

   task automatic test_fairness();
      exp_t e;
      logic win_b;
      apply_reset();
      for (int r = 0; r < 4; r++) begin
         win_b = r[0];
         for (int i = 0; i < 6; i++) begin
            req_a = (i == 0);
            req_b = (i == 0);
            a     = 1'($urandom);
            b     = 1'($urandom);
            push_exp((i < 4) && !win_b, (i < 4) && win_b, win_b);
            tick();
            e = sb.pop_front();
            checks++;
            if ({gnt_a, gnt_b, sel, out} !== {e.ga, e.gb, e.s, e.o}) begin
               errors++;
               $display("FAIL fairness rnd %0d cyc %0d: got ga=%b gb=%b sel=%b out=%b want ga=%b gb=%b sel=%b out=%b",
                        r, i, gnt_a, gnt_b, sel, out, e.ga, e.gb, e.s, e.o);
            end
         end
      end
   endtask

   task automatic test_rearbitrate();
      exp_t e;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         req_a = (i == 0) || (i >= 5);
         req_b = (i >= 5);
         a     = 1'($urandom);
         b     = 1'($urandom);
         push_exp(i < 4, i >= 5, i >= 5);
         tick();
         e = sb.pop_front();
         checks++;
         if ({gnt_a, gnt_b, sel, out} !== {e.ga, e.gb, e.s, e.o}) begin
            errors++;
            $display("FAIL rearbitrate cyc %0d: got ga=%b gb=%b sel=%b out=%b want ga=%b gb=%b sel=%b out=%b",
                     i, gnt_a, gnt_b, sel, out, e.ga, e.gb, e.s, e.o);
         end
      end
   endtask

   task automatic test_timeout();
      exp_t e;
      logic exp_a;
      apply_reset();
      for (int i = 0; i < 20; i++) begin
         req_a = 1'b1;
         req_b = (i >= 3);
         a     = 1'($urandom);
         b     = 1'($urandom);
`ifdef MUX_ARB_TIMEOUT_EN
         exp_a = (i < 16);
`else
         exp_a = 1'b1;
`endif
         push_exp(exp_a, !exp_a, !exp_a);
         tick();
         e = sb.pop_front();
         checks++;
         if ({gnt_a, gnt_b, sel, out} !== {e.ga, e.gb, e.s, e.o}) begin
            errors++;
            $display("FAIL timeout cyc %0d: got ga=%b gb=%b sel=%b out=%b want ga=%b gb=%b sel=%b out=%b",
                     i, gnt_a, gnt_b, sel, out, e.ga, e.gb, e.s, e.o);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      logic exp_b;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         rst   = (i == 3);
         req_a = 1'b0;
         req_b = 1'b1;
         a     = 1'($urandom);
         b     = 1'($urandom);
         exp_b = (i != 3);
         push_exp(1'b0, exp_b, exp_b);
         tick();
         e = sb.pop_front();
         checks++;
         if ({gnt_a, gnt_b, sel, out} !== {e.ga, e.gb, e.s, e.o}) begin
            errors++;
            $display("FAIL mid_reset cyc %0d: got ga=%b gb=%b sel=%b out=%b want ga=%b gb=%b sel=%b out=%b",
                     i, gnt_a, gnt_b, sel, out, e.ga, e.gb, e.s, e.o);
         end
      end
      rst = 1'b0;
   endtask

   // Grants must never overlap on any sampled cycle.
   always @(negedge clk) begin
      if (!rst && gnt_a && gnt_b) begin
         errors++;
         $display("FAIL exclusive: got ga=%b gb=%b want at most one high", gnt_a, gnt_b);
      end
   end

   // Absolute time bound so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_min_hold();
      test_round_robin();
      test_fairness();
      test_rearbitrate();
      test_timeout();
      test_mid_reset();
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d leftover want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mux_arbiter

`default_nettype wire

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: minimum number of cycles a grant is held once given; legal range 1..MAX_CYCLES.
REQ-002 Parameter MAX_CYCLES, default 16: grant length after which the owner is pre-empted; used only when MUX_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_a  input  1  requester A wants the shared output.
REQ-007 req_b  input  1  requester B wants the shared output.
REQ-008 a  input  1  requester A data.
REQ-009 b  input  1  requester B data.
REQ-010 gnt_a  output  1  A owns the output (registered).
REQ-011 gnt_b  output  1  B owns the output (registered).
REQ-012 sel  output  1  mux select (registered); 0 selects a, 1 selects b.
REQ-013 out  output  1  shared output: a when sel=0, b when sel=1; combinational from a, b and sel.

Function
REQ-014 FSM states SHALL be IDLE, OWN_A and OWN_B, with gnt_a=1 only in OWN_A and gnt_b=1 only in OWN_B.
REQ-015 gnt_a and gnt_b SHALL never both be 1.
REQ-016 Grant latency from IDLE SHALL be 1 cycle: a request sampled at edge N gives a grant visible after edge N.
REQ-017 sel SHALL be 0 in OWN_A and 1 in OWN_B, and SHALL keep its last value in IDLE.
REQ-018 When both requests are high in IDLE, the grant SHALL go to the requester not served last; the last_owner register resets to B, so A wins first.
REQ-019 hold_cnt SHALL load 1 on entry to an OWN state, increment each cycle, and saturate at MAX_CYCLES; its width is $clog2(MAX_CYCLES+1).
REQ-020 The owner SHALL keep its grant while hold_cnt < HOLD_CYCLES, even if its request drops.
REQ-021 The owner SHALL release when its request is low and hold_cnt >= HOLD_CYCLES: to the other OWN state if the other request is high, with no IDLE bubble, otherwise to IDLE.
REQ-022 On a handover, gnt and sel SHALL change on the same edge, so out switches source in one cycle with no dead cycle.
REQ-023 If the owner's request rises again in the same cycle it releases, the release SHALL still happen and the request SHALL be arbitrated afresh under REQ-018.

Reset
REQ-024 While rst=1 at a clock edge: state=IDLE, gnt_a=0, gnt_b=0, sel=0, hold_cnt=0, last_owner=B.
REQ-025 Reset applied mid-grant SHALL drop the grant on that edge and discard any pending pre-emption.
REQ-026 Requests seen during reset SHALL be ignored; arbitration starts on the first edge with rst=0.

Configuration
REQ-027 Macro MUX_ARB_TIMEOUT_EN defined: when hold_cnt >= MAX_CYCLES and the other request is high, the owner SHALL be pre-empted on the next edge and the grant passes directly to the other requester.
REQ-028 Macro MUX_ARB_TIMEOUT_EN undefined: there is no pre-emption; the owner keeps the grant while its request is high, and MAX_CYCLES only bounds hold_cnt saturation.

Structure
REQ-029 Package mux_arb_pkg SHALL hold the state enum (IDLE, OWN_A, OWN_B) and the owner encoding (OWNER_A=0, OWNER_B=1, matching sel).
REQ-030 The existing 2:1 mux SHALL be instantiated as sub-module mux (ports a, b, sel, out) to produce out; the arbiter adds no other datapath.

Verification
REQ-031 Reset priority: rst=1 with req_a=req_b=1 -> gnt_a=gnt_b=0, sel=0; release rst -> gnt_a=1 one cycle later.
REQ-032 Minimum hold: req_a pulsed 1 cycle, HOLD_CYCLES=4 -> gnt_a high exactly 4 cycles; out follows a throughout.
REQ-033 Round-robin: req_a=req_b=1 from IDLE; drop req_a after 5 cycles -> gnt_b and sel=1 on the next edge, no IDLE cycle; out equals b thereafter.
REQ-034 Fairness: after B is served, both requesting from IDLE -> A granted; sequence repeated 4 times alternates A, B, A, B.
REQ-035 Timeout (macro on, MAX_CYCLES=16): req_a held high, req_b raised at cycle 3 -> gnt_a drops after its 16th grant cycle and gnt_b rises on the same edge; macro off -> gnt_a holds indefinitely.
REQ-036 Mid-grant reset: rst pulsed during OWN_B -> next cycle gnt_b=0, sel=0; with req_b still high -> gnt_b=1 after one further cycle.
